data_cache_ctrl: RTL
====================

# data_cache_ctrl

Parametrised, clocked successor to the combinational trace-driven data cache. It models a set-associative, write-back, write-allocate L1 data cache with true LRU replacement. It accepts trace commands over a valid/ready handshake and issues line-granular writeback and fill requests to the next-level cache over a second handshake. It sits between the trace reader and the L2 model and feeds the statistics module.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- OFFSET_W, 6, line offset bits (64-byte lines)
- SETS, 16384, number of sets (power of two, ≥2); INDEX_W = log2(SETS)
- WAYS, 4, associativity (power of two, 2..16); AGE_W = log2(WAYS)
- TAG_W = ADDR_W − INDEX_W − OFFSET_W (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  trace command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  0=READ, 1=WRITE, 3=INVALIDATE, 8=RESET, 9=PRINT; other codes are accepted and ignored
- cmd_addr  in  ADDR_W  byte address
- l2_valid  out  1  L2 request present
- l2_ready  in  1  L2 accepts request
- l2_op  out  1  0=FILL read, 1=WRITEBACK
- l2_addr  out  ADDR_W−OFFSET_W  line address
- hits, misses, reads, writes, writebacks  out  32 each  statistics counters
- print_pulse  out  1  one-cycle strobe on PRINT

## Operation
- Per set: valid, dirty and TAG_W tag per way, plus an AGE_W age per way. Ages in a set are always a permutation of 0..WAYS−1, and WAYS−1 is the LRU way.
- FSM states: CLEAR, IDLE, LOOKUP, EVICT, FILL.
- CLEAR: sweeps one set per cycle, index 0..SETS−1. Each set gets valid=0, dirty=0, tag=0, age[w]=w. Exits to IDLE after set SETS−1.
- IDLE: cmd_ready=1. A handshake latches op and address. READ/WRITE/INVALIDATE go to LOOKUP. RESET zeroes all counters and goes to CLEAR. PRINT pulses print_pulse and stays in IDLE. Other codes stay in IDLE.
- LOOKUP, READ/WRITE: reads++ or writes++.
  - Hit (valid and tag match, lowest matching way wins): hits++. The accessed way gets age 0. Every way with age < the accessed way's old age increments. WRITE sets dirty. Next state IDLE.
  - Miss: misses++. Victim is the lowest-index invalid way, or else the way with age WAYS−1. A dirty victim goes to EVICT; otherwise FILL.
- EVICT: l2_valid=1, l2_op=1, l2_addr={victim tag, index}. On l2_ready, writebacks++.
  - For a miss: next state FILL.
  - For an invalidate: clear valid and dirty, next state IDLE.
- FILL: l2_valid=1, l2_op=0, l2_addr=cmd line address. On l2_ready:
  - install the tag, valid=1, dirty=(op==WRITE);
  - apply the LRU update to the victim;
  - next state IDLE.
- LOOKUP, INVALIDATE:
  - Hit on a dirty line goes to EVICT.
  - Hit on a clean line clears valid and goes to IDLE.
  - Miss goes to IDLE.
  - No counter changes; ages are unchanged.
- Counters wrap modulo 2^32.

## Timing
- Async rst: state=CLEAR, all counters=0, cmd_ready=0, l2_valid=0, print_pulse=0. cmd_ready first rises SETS cycles after rst deasserts.
- Array reads are registered. The lookup result is available in LOOKUP, one cycle after accept.
- Hit latency: accept edge, then LOOKUP; cmd_ready is high again 2 cycles after accept.
- Clean miss: 2 + FILL wait cycles. Dirty miss additionally incurs the EVICT wait.
- l2_valid/l2_op/l2_addr are held stable until l2_ready is sampled high. l2_valid drops the cycle after the handshake. l2_ready while l2_valid=0 is ignored.
- cmd_ready=0 in every state except IDLE. cmd_valid is ignored there.
- Counters update on the clock edge ending LOOKUP (hit/miss/read/write) or ending the L2 handshake (writebacks).
- rst asserted mid-EVICT/FILL aborts the L2 request immediately (l2_valid=0 asynchronously) and restarts CLEAR.

## Structure
- Package dcache_pkg: op code constants, L2 op constants, FSM state enum, and the derived-width functions (TAG_W, INDEX_W, AGE_W).
- Sub-module lru_age_update: combinational. Inputs: the age vector of a set and the accessed way. Outputs: the new age vector and the LRU way.
- Arrays are inferred memories indexed by set; there is no reset port on the arrays, and clearing is done only via CLEAR.

## Test plan
Run with SETS=16, WAYS=4.
- Reset → cmd_ready=0 for 16 cycles, then 1; all counters 0.
- READ 0x0000_0040 twice (L2 ready immediately) → first is a FILL to line 0x000001, misses=1; second is a hit, hits=1, reads=2, no L2 request.
- WRITE to 5 addresses sharing index 1 (tags 0..4) with 0 reads in between → fifth write issues WRITEBACK of tag 0 then FILL of tag 4; writebacks=1, misses=5.
- READ tags 0,1,2,3 in set 2, re-read tag 0, read tag 4 → victim is tag 1; a READ of tag 0 afterwards hits.
- WRITE A, then INVALIDATE A → WRITEBACK of A, writebacks=1; a following READ A misses.
- Hold l2_ready=0 for 10 cycles during FILL, then assert rst → l2_valid drops immediately, counters 0, CLEAR restarts; PRINT after the sweep gives a one-cycle print_pulse.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encoding and width helpers for the L1 data cache controller.
package dcache_pkg;

    localparam logic [3:0] OP_READ       = 4'd0;
    localparam logic [3:0] OP_WRITE      = 4'd1;
    localparam logic [3:0] OP_INVALIDATE = 4'd3;
    localparam logic [3:0] OP_RESET      = 4'd8;
    localparam logic [3:0] OP_PRINT      = 4'd9;

    localparam logic L2_FILL      = 1'b0;
    localparam logic L2_WRITEBACK = 1'b1;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL
    } state_t;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int index_w(input int sets);
        return log2_ceil(sets);
    endfunction

    function automatic int age_w(input int ways);
        return log2_ceil(ways);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int offset_w);
        return addr_w - log2_ceil(sets) - offset_w;
    endfunction

endpackage

// File: rtl/data_cache_ctrl_lru.sv
// True-LRU age update for one set: accessed way becomes youngest, younger ways age by one.
module lru_age_update #(
    parameter int WAYS  = 4,
    parameter int AGE_W = 2
) (
    input  logic [WAYS-1:0][AGE_W-1:0] ages,
    input  logic [AGE_W-1:0]           way,
    output logic [WAYS-1:0][AGE_W-1:0] new_ages,
    output logic [AGE_W-1:0]           lru_way
);

    always_comb begin
        new_ages = ages;
        lru_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == way) begin
                new_ages[w] = '0;
            end else if (ages[w] < ages[way]) begin
                new_ages[w] = ages[w] + 1'b1;
            end
            if (ages[w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Clocked set-associative write-back/write-allocate L1 data cache controller with true LRU.
module data_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int SETS     = 16384,
    parameter int WAYS     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [ADDR_W-1:0]          cmd_addr,
    output logic                       l2_valid,
    input  logic                       l2_ready,
    output logic                       l2_op,
    output logic [ADDR_W-OFFSET_W-1:0] l2_addr,
    output logic [31:0]                hits,
    output logic [31:0]                misses,
    output logic [31:0]                reads,
    output logic [31:0]                writes,
    output logic [31:0]                writebacks,
    output logic                       print_pulse
);

    localparam int INDEX_W = index_w(SETS);
    localparam int AGE_W   = age_w(WAYS);
    localparam int TAG_W   = tag_w(ADDR_W, SETS, OFFSET_W);
    localparam int LINE_W  = ADDR_W - OFFSET_W;

    typedef struct packed {
        logic [WAYS-1:0]            valid;
        logic [WAYS-1:0]            dirty;
        logic [WAYS-1:0][TAG_W-1:0] tag;
        logic [WAYS-1:0][AGE_W-1:0] age;
    } set_t;

    set_t               mem [0:SETS-1];
    set_t               set_q, clear_set, mem_wdata;
    logic               mem_we;
    logic [INDEX_W-1:0] mem_idx, clr_idx;

    state_t             state, next_state;
    logic [3:0]         op_q;
    logic [LINE_W-1:0]  line_q;
    logic [AGE_W-1:0]   victim_q, hit_way, inv_way, miss_victim, lru_way, upd_way;
    logic               hit, has_inv, accept;
    logic [WAYS-1:0][AGE_W-1:0] new_ages;
    logic               unused_offset;

    wire [INDEX_W-1:0] idx_q   = line_q[INDEX_W-1:0];
    wire [TAG_W-1:0]   tag_q   = line_q[LINE_W-1:INDEX_W];
    wire [INDEX_W-1:0] cmd_idx = cmd_addr[OFFSET_W +: INDEX_W];

    assign unused_offset = ^cmd_addr[OFFSET_W-1:0];
    assign accept        = cmd_valid && cmd_ready;
    assign upd_way       = (state == ST_FILL) ? victim_q : hit_way;

    lru_age_update #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
        .ages     (set_q.age),
        .way      (upd_way),
        .new_ages (new_ages),
        .lru_way  (lru_way)
    );

    always_comb begin
        clear_set = '0;
        for (int w = 0; w < WAYS; w++) clear_set.age[w] = AGE_W'(w);
    end

    // Descending scans so the lowest-index matching/invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_q.valid[w] && set_q.tag[w] == tag_q) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!set_q.valid[w]) begin
                has_inv = 1'b1;
                inv_way = AGE_W'(w);
            end
        end
        miss_victim = has_inv ? inv_way : lru_way;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_CLEAR;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        l2_valid   = 1'b0;
        l2_op      = L2_FILL;
        l2_addr    = line_q;
        mem_we     = 1'b0;
        mem_idx    = idx_q;
        mem_wdata  = set_q;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_idx;
                mem_wdata = clear_set;
                if (clr_idx == INDEX_W'(SETS - 1)) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ, OP_WRITE, OP_INVALIDATE: next_state = ST_LOOKUP;
                        OP_RESET:                         next_state = ST_CLEAR;
                        default:                          next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LOOKUP: begin
                if (op_q == OP_INVALIDATE) begin
                    if (hit && set_q.dirty[hit_way]) begin
                        next_state = ST_EVICT;
                    end else begin
                        mem_we                   = hit;
                        mem_wdata.valid[hit_way] = 1'b0;
                        next_state               = ST_IDLE;
                    end
                end else if (hit) begin
                    mem_we        = 1'b1;
                    mem_wdata.age = new_ages;
                    if (op_q == OP_WRITE) mem_wdata.dirty[hit_way] = 1'b1;
                    next_state = ST_IDLE;
                end else if (set_q.valid[miss_victim] && set_q.dirty[miss_victim]) begin
                    next_state = ST_EVICT;
                end else begin
                    next_state = ST_FILL;
                end
            end
            ST_EVICT: begin
                l2_valid = 1'b1;
                l2_op    = L2_WRITEBACK;
                l2_addr  = {set_q.tag[victim_q], idx_q};
                if (l2_ready) begin
                    if (op_q == OP_INVALIDATE) begin
                        mem_we                    = 1'b1;
                        mem_wdata.valid[victim_q] = 1'b0;
                        mem_wdata.dirty[victim_q] = 1'b0;
                        next_state                = ST_IDLE;
                    end else begin
                        next_state = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                l2_valid = 1'b1;
                if (l2_ready) begin
                    mem_we                    = 1'b1;
                    mem_wdata.tag[victim_q]   = tag_q;
                    mem_wdata.valid[victim_q] = 1'b1;
                    mem_wdata.dirty[victim_q] = (op_q == OP_WRITE);
                    mem_wdata.age             = new_ages;
                    next_state                = ST_IDLE;
                end
            end
            default: next_state = ST_CLEAR;
        endcase
    end

    // Set storage has no reset; the CLEAR sweep is the only initialisation.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wdata;
        if (accept) set_q <= mem[cmd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            line_q      <= '0;
            victim_q    <= '0;
            clr_idx     <= '0;
            hits        <= '0;
            misses      <= '0;
            reads       <= '0;
            writes      <= '0;
            writebacks  <= '0;
            print_pulse <= 1'b0;
        end else begin
            print_pulse <= accept && (cmd_op == OP_PRINT);
            if (accept) begin
                op_q   <= cmd_op;
                line_q <= cmd_addr[ADDR_W-1:OFFSET_W];
            end
            // Wraps back to zero at the end of a sweep, ready for the next CLEAR.
            if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
            if (accept && cmd_op == OP_RESET) begin
                hits       <= '0;
                misses     <= '0;
                reads      <= '0;
                writes     <= '0;
                writebacks <= '0;
            end
            if (state == ST_LOOKUP) begin
                if (op_q == OP_INVALIDATE) begin
                    victim_q <= hit_way;
                end else begin
                    victim_q <= hit ? hit_way : miss_victim;
                    if (op_q == OP_READ) reads  <= reads + 32'd1;
                    else                 writes <= writes + 32'd1;
                    if (hit) hits   <= hits + 32'd1;
                    else     misses <= misses + 32'd1;
                end
            end
            if (state == ST_EVICT && l2_ready) writebacks <= writebacks + 32'd1;
        end
    end

endmodule
